// File: rtl/tile_spawner.sv
// Places one new tile on the 4x4 board: random start cell, forward scan with wrap to
// the first empty cell, then a second random sample picks tile value 2 or 4.
module tile_spawner #(
    parameter int N_CELLS  = 16,
    parameter int VAL_WAIT = 4,
    parameter int FOUR_NUM = 1
) (
    input  logic                       CLK100MHZ,
    input  logic                       CPU_RESET,
    input  logic [$clog2(N_CELLS)-1:0] rnd,
    input  logic [N_CELLS-1:0]         empty_mask,
    input  logic                       spawn_req,
    input  logic                       spawn_ack,
    output logic                       busy,
    output logic                       spawn_valid,
    output logic [$clog2(N_CELLS)-1:0] spawn_pos,
    output logic [1:0]                 spawn_exp,
    output logic                       board_full
);

    localparam int PTR_W  = $clog2(N_CELLS);
    localparam int SCAN_W = PTR_W + 1;
    localparam int WCNT_W = (VAL_WAIT > 1) ? $clog2(VAL_WAIT) : 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(N_CELLS - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(VAL_WAIT - 1);
    localparam logic [SCAN_W-1:0] FOUR_LIM  = SCAN_W'(FOUR_NUM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [N_CELLS-1:0]  r_snap;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_busy;
    logic                r_valid;
    logic [PTR_W-1:0]    r_pos;
    logic [1:0]          r_exp;
    logic                r_full;

    logic                w_hit;
    logic                w_last_cell;
    logic                w_wait_done;
    logic [1:0]          w_exp_sel;

    assign w_hit       = r_snap[r_ptr];
    assign w_last_cell = (r_scan_cnt == SCAN_LAST);
    assign w_wait_done = (r_wcnt == WAIT_LAST);
    // Exponent 2 (tile 4) on the rare branch, exponent 1 (tile 2) otherwise.
    assign w_exp_sel   = ({1'b0, rnd} < FOUR_LIM) ? 2'd2 : 2'd1;

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_snap     <= '0;
            r_scan_cnt <= '0;
            r_wcnt     <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_pos      <= '0;
            r_exp      <= '0;
            r_full     <= 1'b0;
        end else begin
            r_full <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (spawn_req) begin
                        // The board is frozen here; later mask changes do not affect this spawn.
                        r_ptr      <= rnd;
                        r_snap     <= empty_mask;
                        r_scan_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_pos   <= r_ptr;
                        r_wcnt  <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_ptr      <= r_ptr + 1'b1;
                        r_scan_cnt <= r_scan_cnt + 1'b1;
                        if (w_last_cell) begin
                            r_full  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    // Waiting a full LFSR refresh keeps the value sample independent of the position.
                    r_wcnt <= r_wcnt + 1'b1;
                    if (w_wait_done) begin
                        r_exp   <= w_exp_sel;
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (spawn_ack) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign spawn_valid = r_valid;
    assign spawn_pos   = r_pos;
    assign spawn_exp   = r_exp;
    assign board_full  = r_full;

endmodule

// File: doc/tile_spawner.md
Name: tile_spawner

Overview:
- Consumes the 4-bit pseudo-random value from the LFSR stage and places one new tile on the 4x4 board after each move.
- On request, picks a random start cell, scans forward with wrap-around to the first empty cell, then takes a fresh random sample to choose tile value 2 or 4.
- Presents the result to the board controller on a valid/ack handshake.
- Reports a one-cycle board_full pulse when no cell is empty.

Parameters:
- N_CELLS, 16, number of board cells. Fixed to 16; cell index = rnd width.
- VAL_WAIT, 4, cycles spent in WAIT before the value sample. Matches the LFSR output refresh period, so the value sample is independent of the position sample.
- FOUR_NUM, 1, spawn a 4 when the sampled rnd < FOUR_NUM (default gives a 1/16 chance).

Ports:
- CLK100MHZ  in  1  system clock, all state on rising edge.
- CPU_RESET  in  1  asynchronous, active-high reset.
- rnd  in  4  random value from the LFSR stage.
- empty_mask  in  16  bit i = 1 when cell i is empty.
- spawn_req  in  1  request one spawn; sampled only in IDLE.
- spawn_ack  in  1  board controller has consumed the result.
- busy  out  1  high whenever state != IDLE.
- spawn_valid  out  1  result available; held until acked.
- spawn_pos  out  4  cell index of the new tile.
- spawn_exp  out  2  tile exponent: 1 = tile 2, 2 = tile 4.
- board_full  out  1  one-cycle pulse: request found no empty cell.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; all outputs 0; ptr, scan_cnt, wcnt, snapshot all 0.
  - Reset asserted in any state aborts the operation; no partial result is emitted.
- States: IDLE, SCAN, WAIT, DONE. All outputs are registered.
- IDLE:
  - On an edge with spawn_req = 1 (call it E0): ptr <= rnd, snap <= empty_mask, scan_cnt <= 0, go to SCAN.
  - Changes to empty_mask after E0 are ignored; the snapshot is used.
- SCAN (one cell per cycle):
  - If snap[ptr] = 1: latch spawn_pos <= ptr, wcnt <= 0, go to WAIT.
  - Else: ptr <= ptr + 1 (mod 16, so 15 wraps to 0), scan_cnt <= scan_cnt + 1.
  - If the 16th cell checked is occupied (scan_cnt = 15 and snap[ptr] = 0): go to IDLE and pulse board_full for exactly the next cycle. spawn_valid stays 0.
- WAIT:
  - wcnt increments each edge.
  - On the edge where wcnt = VAL_WAIT-1: spawn_exp <= (rnd < FOUR_NUM) ? 2 : 1, go to DONE.
- DONE:
  - spawn_valid = 1; spawn_pos and spawn_exp held stable.
  - On an edge with spawn_ack = 1: go to IDLE; spawn_valid drops the next cycle.
  - spawn_pos and spawn_exp keep their last values after ack (don't-care when valid = 0).
- Latency: spawn_valid rises 1 + k + VAL_WAIT cycles after E0, where k (0..15) = occupied cells skipped. Full board: board_full high in the 17th cycle after E0.
- Simultaneous events:
  - spawn_req while busy (including on the ack edge): ignored, not queued.
  - spawn_ack outside DONE: ignored.
- Arithmetic:
  - ptr is 4-bit with natural wrap.
  - scan_cnt is 5-bit (or compare at 15).
  - wcnt is sized to clog2(VAL_WAIT); VAL_WAIT >= 1.

Test Plan:
- All-empty board: empty_mask = 16'hFFFF, rnd = 5 at E0, rnd = 3 during the last WAIT cycle -> spawn_pos = 5, spawn_exp = 1, spawn_valid high 5 cycles after E0, busy high throughout.
- Wrap-around: empty_mask = 16'h0001, rnd = 14 at E0 -> cells 14, 15, 0 checked; spawn_pos = 0; valid 7 cycles after E0.
- Full board: empty_mask = 16'h0000 -> board_full high for exactly 1 cycle (17th after E0), spawn_valid never high, busy low afterwards, a new request accepted next edge.
- Value select: rnd = 0 at the value sample -> spawn_exp = 2. Repeat with rnd = 1 -> spawn_exp = 1.
- Handshake hold and ignore:
  - Withhold spawn_ack for 10 cycles in DONE -> valid/pos/exp stable; spawn_req pulses during busy ignored.
  - Ack -> valid low next cycle; a toggle of empty_mask during SCAN does not change the result.
- Reset mid-operation: assert CPU_RESET between clock edges during SCAN -> all outputs 0 immediately (no clock edge). After release, idle until a new spawn_req, then normal 5-cycle spawn.
